instr_fetch_unit: RTL and testbench

- Front-end fetch stage of the 8-bit core.
- Owns the program counter and issues reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned bytes with their PCs in a small queue and hands them to the decode/control stage over a valid/ready handshake.
- Accepts PC redirects (jump/branch) from downstream, flushing all wrong-path state.

---
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads a 1-cycle-latency instruction memory and
// queues {instr, pc} pairs for decode. Redirects flush the queue and any in-flight read.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // p1: the read issued last cycle; its data is on imem_rdata this cycle
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic              discard_p1;

    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];

    logic              not_empty;
    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;

    assign not_empty   = (count != '0);
    assign instr_valid = not_empty & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign push        = vld_p1 & ~discard_p1 & ~redirect_valid;

    // Slots already committed: queued entries plus the returning read, minus the one leaving
    assign occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);

    assign imem_en   = fetch_en & ~redirect_valid & ~reset
                     & (occupancy < (CNT_W+1)'(QDEPTH));
    assign imem_addr = fetch_pc;

    assign instr_data = not_empty ? q_data[rd_ptr] : '0;
    assign instr_pc   = not_empty ? q_pc[rd_ptr]   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            vld_p1     <= 1'b0;
            discard_p1 <= 1'b0;
        end else begin
            discard_p1 <= redirect_valid;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                vld_p1   <= 1'b0;
            end else begin
                vld_p1 <= imem_en;
                if (imem_en)
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Datapath storage carries no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (imem_en)
            pc_p1 <= fetch_pc;
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= pc_p1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-by-cycle bench for instr_fetch_unit against a synchronous
// instruction memory preloaded with mem[i] = i + 8'h10.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_en;
    logic       imem_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata = 8'h00;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .RESET_PC(8'h00),
        .QDEPTH  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
    );

    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input bit v, input logic [7:0] pc);
        logic [7:0] d;
        d = pc + 8'h10;
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            check({tag, ".pc"},   32'(instr_pc),   32'(pc));
            check({tag, ".data"}, 32'(instr_data), 32'(d));
        end
    endtask

    task automatic chk_fetch(input string tag, input bit en, input logic [7:0] addr);
        check({tag, ".imem_en"}, 32'(imem_en), 32'(en));
        if (en)
            check({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i + 16);

        reset          = 1'b1;
        fetch_en       = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        repeat (2) @(posedge clk);
        #4;
        check("rst.imem_en",     32'(imem_en),     32'd0);
        check("rst.instr_valid", 32'(instr_valid), 32'd0);
        check("rst.instr_data",  32'(instr_data),  32'd0);
        check("rst.instr_pc",    32'(instr_pc),    32'd0);

        // Test 1: stream from reset, one instruction per cycle
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #3;
            chk_head($sformatf("t1c%0d", k), k >= 2, 8'(k - 2));
            chk_fetch($sformatf("t1c%0d", k), 1'b1, 8'(k));
            next_cycle();
        end

        // Test 2: decode stalls for 5 cycles
        instr_ready = 1'b0;
        for (int k = 8; k < 13; k++) begin
            #3;
            chk_head($sformatf("t2c%0d", k), 1'b1, 8'h06);
            chk_fetch($sformatf("t2c%0d", k), 1'b0, 8'h00);
            next_cycle();
        end
        instr_ready = 1'b1;
        for (int k = 13; k < 17; k++) begin
            #3;
            chk_head($sformatf("t2c%0d", k), 1'b1, 8'(k - 7));
            chk_fetch($sformatf("t2c%0d", k), 1'b1, 8'(k - 5));
            next_cycle();
        end

        // Test 3: fill the queue, then redirect to 8'h40
        instr_ready = 1'b0;
        #3;
        chk_head("t3c17", 1'b1, 8'h0A);
        chk_fetch("t3c17", 1'b0, 8'h00);
        next_cycle();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        #3;
        chk_head("t3c18", 1'b0, 8'h00);
        chk_fetch("t3c18", 1'b0, 8'h00);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 19; k < 24; k++) begin
            #3;
            chk_head($sformatf("t3c%0d", k), k >= 21, 8'(8'h40 + k - 21));
            chk_fetch($sformatf("t3c%0d", k), 1'b1, 8'(8'h40 + k - 19));
            next_cycle();
        end

        // Test 4: redirect mid-stream to 8'hFE, PC wraps through 8'h00
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        #3;
        chk_head("t4c24", 1'b0, 8'h00);
        chk_fetch("t4c24", 1'b0, 8'h00);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 25; k < 30; k++) begin
            #3;
            chk_head($sformatf("t4c%0d", k), k >= 27, 8'(8'hFE + k - 27));
            chk_fetch($sformatf("t4c%0d", k), 1'b1, 8'(8'hFE + k - 25));
            next_cycle();
        end

        // Test 5: two entries queued, asynchronous reset between edges
        instr_ready = 1'b0;
        #3;
        chk_head("t5c30", 1'b1, 8'h01);
        chk_fetch("t5c30", 1'b0, 8'h00);
        next_cycle();
        #3;
        chk_head("t5c31", 1'b1, 8'h01);
        reset = 1'b1;
        #1;
        check("t5.async.instr_valid", 32'(instr_valid), 32'd0);
        check("t5.async.imem_en",     32'(imem_en),     32'd0);
        check("t5.async.instr_data",  32'(instr_data),  32'd0);
        check("t5.async.instr_pc",    32'(instr_pc),    32'd0);
        @(posedge clk);
        next_cycle();
        reset       = 1'b0;
        instr_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            #3;
            chk_head($sformatf("t5r%0d", r), r >= 2, 8'(r - 2));
            chk_fetch($sformatf("t5r%0d", r), 1'b1, 8'(r));
            next_cycle();
        end

        // Test 6: fetch disabled for 4 cycles, queue drains, then resumes
        fetch_en = 1'b0;
        for (int r = 5; r < 9; r++) begin
            #3;
            chk_head($sformatf("t6r%0d", r), r <= 6, 8'(r - 2));
            chk_fetch($sformatf("t6r%0d", r), 1'b0, 8'h00);
            next_cycle();
        end
        fetch_en = 1'b1;
        for (int r = 9; r < 13; r++) begin
            #3;
            chk_head($sformatf("t6r%0d", r), r >= 11, 8'(r - 6));
            chk_fetch($sformatf("t6r%0d", r), 1'b1, 8'(r - 4));
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
